// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with several requests in flight and a decode queue.
// Optional macro IF_BYPASS_EN forwards a response straight to decode when the queue is empty.
module if_fetch_unit #(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        fs_flush_pipe,
  input  logic [31:0] flush_target,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int BW = $clog2(IBUF_DEPTH + 1);
  localparam int SW = ((CW > BW) ? CW : BW) + 1;
  localparam logic [CW-1:0] MAX_OUT  = CW'(MAX_OUTSTANDING);
  localparam logic [BW-1:0] DEPTH    = BW'(IBUF_DEPTH);
  localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   tag_mem_q [MAX_OUTSTANDING];
  logic [31:0]   tag_mem_d [MAX_OUTSTANDING];
  logic [TW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d, discard_q, discard_d;
  logic [64:0]   ibuf_q [IBUF_DEPTH];
  logic [64:0]   ibuf_d [IBUF_DEPTH];
  logic [PW-1:0] ib_wr_q, ib_wr_d, ib_rd_q, ib_rd_d;
  logic [BW-1:0] ib_cnt_q, ib_cnt_d;
  logic          adef_stall_q, adef_stall_d;

  logic          redirect;
  logic [31:0]   redirect_target;
  logic          resp, resp_live, hs, credit_ok, adef_fire, bypass;
  logic          ib_empty, ib_push, ib_pop;
  logic [64:0]   resp_entry, push_entry;
  logic [SW-1:0] credit_sum;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TAG_LAST) ? '0 : p + TW'(1);
  endfunction

  assign redirect        = fs_flush_pipe | br_taken;
  assign redirect_target = fs_flush_pipe ? flush_target : br_target;
  assign ib_empty        = (ib_cnt_q == '0);

  // A response with nothing in flight is a leftover from before reset.
  assign resp       = inst_sram_data_ok & (out_cnt_q != '0);
  assign resp_live  = resp & !redirect & (discard_q == '0);
  assign resp_entry = {1'b0, inst_sram_rdata, tag_mem_q[tag_rd_q]};

  // Every accepted request owns a queue slot, so responses never need back-pressure.
  assign credit_sum = SW'(out_cnt_q) + SW'(ib_cnt_q);
  assign credit_ok  = credit_sum < SW'(IBUF_DEPTH);

  assign inst_sram_req = resetn & !redirect & !adef_stall_q & (pc_q[1:0] == 2'b00)
                       & (out_cnt_q < MAX_OUT) & credit_ok;
  assign hs = inst_sram_req & inst_sram_addr_ok;

  assign adef_fire = !redirect & !adef_stall_q & (pc_q[1:0] != 2'b00) & (out_cnt_q == '0)
                   & (discard_q == '0) & (ib_cnt_q < DEPTH);

`ifdef IF_BYPASS_EN
  assign bypass = resp_live & ib_empty;
`else
  assign bypass = 1'b0;
`endif

  assign fs_to_ds_valid = resetn & !redirect & (!ib_empty | bypass);
  assign fs_to_ds_bus   = bypass ? resp_entry : ibuf_q[ib_rd_q];
  assign ib_pop         = fs_to_ds_valid & ds_allowin & !ib_empty;
  assign ib_push        = (resp_live & !(bypass & ds_allowin)) | adef_fire;
  assign push_entry     = adef_fire ? {1'b1, 32'h0, pc_q} : resp_entry;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = pc_q;

  always_comb begin
    pc_d         = pc_q;
    tag_mem_d    = tag_mem_q;
    tag_wr_d     = tag_wr_q;
    tag_rd_d     = tag_rd_q;
    out_cnt_d    = out_cnt_q + CW'(hs) - CW'(resp);
    discard_d    = discard_q;
    ibuf_d       = ibuf_q;
    ib_wr_d      = ib_wr_q;
    ib_rd_d      = ib_rd_q;
    ib_cnt_d     = ib_cnt_q;
    adef_stall_d = adef_stall_q;

    if (hs) begin
      tag_mem_d[tag_wr_q] = pc_q;
      tag_wr_d            = tag_next(tag_wr_q);
    end
    if (resp) tag_rd_d = tag_next(tag_rd_q);

    if (redirect) begin
      // Everything still in flight after this edge belongs to the old path.
      pc_d         = redirect_target;
      ib_wr_d      = '0;
      ib_rd_d      = '0;
      ib_cnt_d     = '0;
      adef_stall_d = 1'b0;
      discard_d    = out_cnt_q - CW'(resp);
    end else begin
      if (hs) pc_d = pc_q + 32'd4;
      if (resp && discard_q != '0) discard_d = discard_q - CW'(1);
      if (ib_push) begin
        ibuf_d[ib_wr_q] = push_entry;
        ib_wr_d         = ib_wr_q + PW'(1);
      end
      if (ib_pop) ib_rd_d = ib_rd_q + PW'(1);
      ib_cnt_d = ib_cnt_q + BW'(ib_push) - BW'(ib_pop);
      if (adef_fire) adef_stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q         <= RESET_PC;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      out_cnt_q    <= '0;
      discard_q    <= '0;
      ib_wr_q      <= '0;
      ib_rd_q      <= '0;
      ib_cnt_q     <= '0;
      adef_stall_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      tag_wr_q     <= tag_wr_d;
      tag_rd_q     <= tag_rd_d;
      out_cnt_q    <= out_cnt_d;
      discard_q    <= discard_d;
      ib_wr_q      <= ib_wr_d;
      ib_rd_q      <= ib_rd_d;
      ib_cnt_q     <= ib_cnt_d;
      adef_stall_q <= adef_stall_d;
    end
  end

  // Storage arrays carry no reset; their pointers and counts define validity.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
    ibuf_q    <= ibuf_d;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: SRAM-like slave with random latency, an address-level
// fetch model with an expected-delivery queue, a redirect vector table and random traffic.
module tb_if_fetch_unit;

  localparam int          MAX_OUTSTANDING = 2;
  localparam int          IBUF_DEPTH      = 4;
  localparam logic [31:0] RESET_PC        = 32'h1c000000;
`ifdef IF_BYPASS_EN
  localparam int LAT_EXP = 0;
`else
  localparam int LAT_EXP = 1;
`endif

  logic        clk, resetn, ds_allowin, br_taken, fs_flush_pipe;
  logic [31:0] br_target, flush_target;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;

  if_fetch_unit #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING), .IBUF_DEPTH(IBUF_DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .resetn(resetn), .ds_allowin(ds_allowin),
    .br_taken(br_taken), .br_target(br_target),
    .fs_flush_pipe(fs_flush_pipe), .flush_target(flush_target),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ready;
    int          epoch;
  } pend_t;

  typedef struct {
    bit          br;
    logic [31:0] bt;
    bit          fl;
    logic [31:0] ft;
    int          lat;
    bit          exp_ex;
    logic [31:0] exp_pc;
  } vec_t;

  pend_t       pend_q[$];
  logic [64:0] exp_q[$];
  vec_t        vecs[7];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, cur_epoch = 0;
  int ok_pct = 100, allow_pct = 100, lat_min = 1, lat_max = 1;
  int hs_count = 0, n_del = 0, max_pend = 0, req_seen = 0;
  int first_dok = -1, first_del_cyc = -1;
  bit first_del_v = 0, prev_redir = 0, t1_req = 0;
  logic [64:0] first_del = '0;
  logic [31:0] t1_addr = '0, exp_req_pc = RESET_PC;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h5a5a0f0f;
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive inputs at negedge, sample #1 later, update model, then the edge.
  task automatic step(input bit br, input logic [31:0] bt, input bit fl, input logic [31:0] ft);
    bit redir, hs;
    logic [31:0] tgt;
    pend_t p;
    logic [64:0] e;
    @(negedge clk);
    br_taken          = br;
    br_target         = bt;
    fs_flush_pipe     = fl;
    flush_target      = ft;
    inst_sram_addr_ok = ($urandom_range(99) < ok_pct);
    ds_allowin        = ($urandom_range(99) < allow_pct);
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = $urandom;
    if (pend_q.size() > 0 && cyc >= pend_q[0].ready) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = inst_of(pend_q[0].addr);
    end
    #1;
    redir = br | fl;
    tgt   = fl ? ft : bt;
    if (prev_redir) begin
      t1_req  = inst_sram_req;
      t1_addr = inst_sram_addr;
    end
    if (redir) begin
      chk("valid_in_redirect", fs_to_ds_valid, 0);
      chk("req_in_redirect", inst_sram_req, 0);
    end
    if (pend_q.size() >= MAX_OUTSTANDING) chk("req_at_max_outstanding", inst_sram_req, 0);
    if (inst_sram_req) begin
      chk("req_addr", inst_sram_addr, exp_req_pc);
      chk("req_aligned", inst_sram_addr[1:0], 0);
      req_seen++;
    end
    hs = inst_sram_req & inst_sram_addr_ok;
    if (inst_sram_data_ok) begin
      p = pend_q.pop_front();
      if (p.epoch == cur_epoch && !redir) begin
        chk("ibuf_credit", exp_q.size() < IBUF_DEPTH, 1);
        exp_q.push_back({1'b0, inst_of(p.addr), p.addr});
        if (first_dok < 0) first_dok = cyc;
      end
    end
    if (fs_to_ds_valid && ds_allowin) begin
      chk("delivery_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fs_to_ds_bus", fs_to_ds_bus, e);
      end
      if (!first_del_v) begin
        first_del_v   = 1;
        first_del     = fs_to_ds_bus;
        first_del_cyc = cyc;
      end
      n_del++;
    end
    if (hs) begin
      pend_q.push_back('{inst_sram_addr, cyc + $urandom_range(lat_max, lat_min), cur_epoch});
      exp_req_pc += 32'd4;
      hs_count++;
    end
    if (pend_q.size() > max_pend) max_pend = pend_q.size();
    if (redir) begin
      cur_epoch++;
      exp_q.delete();
      exp_req_pc = tgt;
      if (tgt[1:0] != 2'b00) exp_q.push_back({1'b1, 32'h0, tgt});
      first_del_v = 0;
      first_dok   = -1;
      req_seen    = 0;
    end
    prev_redir = redir;
    @(posedge clk);
    cyc++;
  endtask

  task automatic step0();
    step(0, 32'h0, 0, 32'h0);
  endtask

  // Reset with an optional stray response in the first cycle after release.
  task automatic do_reset(input bit stray);
    @(negedge clk);
    resetn = 0; br_taken = 0; fs_flush_pipe = 0; ds_allowin = 0;
    inst_sram_addr_ok = 0; inst_sram_data_ok = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("req_during_reset", inst_sram_req, 0);
    resetn            = 1;
    inst_sram_data_ok = stray;
    inst_sram_rdata   = 32'hdeadbeef;
    #1;
    chk("reset_valid", fs_to_ds_valid, 0);
    chk("reset_req", inst_sram_req, 1);
    chk("reset_addr", inst_sram_addr, RESET_PC);
    pend_q.delete();
    exp_q.delete();
    cur_epoch++;
    exp_req_pc  = RESET_PC;
    first_del_v = 0; first_dok = -1; first_del_cyc = -1;
    prev_redir  = 0; max_pend = 0; req_seen = 0;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    int n0, h0;
    resetn = 0; ds_allowin = 0; br_taken = 0; fs_flush_pipe = 0;
    br_target = '0; flush_target = '0;
    inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = '0;

    vecs[0] = '{1, 32'h1c000100, 0, 32'h0,        1, 0, 32'h1c000100};
    vecs[1] = '{1, 32'h1c000200, 1, 32'h1c008000, 2, 0, 32'h1c008000};
    vecs[2] = '{0, 32'h0,        1, 32'h1c000040, 1, 0, 32'h1c000040};
    vecs[3] = '{1, 32'h1c000102, 0, 32'h0,        1, 1, 32'h1c000102};
    vecs[4] = '{1, 32'h1c000010, 0, 32'h0,        2, 0, 32'h1c000010};
    vecs[5] = '{1, 32'h1c000300, 1, 32'h1c000203, 1, 1, 32'h1c000203};
    vecs[6] = '{1, 32'hfffffff8, 0, 32'h0,        1, 0, 32'hfffffff8};

    // reset state, stray response ignored, tie-offs
    do_reset(1);
    chk("stray_ignored_valid", fs_to_ds_valid, 0);
    chk("tie_wr", inst_sram_wr, 0);
    chk("tie_size", inst_sram_size, 2);
    chk("tie_wstrb", inst_sram_wstrb, 0);
    chk("tie_wdata", inst_sram_wdata, 0);

    // back-to-back fetch from RESET_PC
    lat_min = 1; lat_max = 1; ok_pct = 100; allow_pct = 100;
    do_reset(0);
    repeat (10) step0();
    n0 = n_del;
    repeat (10) step0();
    chk("throughput", n_del - n0, 10);
    chk("first_pc", first_del[31:0], RESET_PC);
    chk("resp_latency", first_del_cyc - first_dok, LAT_EXP);

    // slow responses: outstanding limit
    lat_min = 5; lat_max = 5;
    do_reset(0);
    repeat (30) step0();
    chk("max_outstanding", max_pend, MAX_OUTSTANDING);

    // decode stalled: credit rule caps accepted requests at the queue depth
    lat_min = 1; lat_max = 1; allow_pct = 0;
    do_reset(0);
    h0 = hs_count;
    repeat (10) step0();
    chk("hs_with_decode_stalled", hs_count - h0, IBUF_DEPTH);
    chk("held_entries", exp_q.size(), IBUF_DEPTH);
    allow_pct = 100; ok_pct = 0;
    repeat (10) step0();
    chk("stall_release_drained", exp_q.size(), 0);

    // branch with two requests in flight
    lat_min = 4; lat_max = 4; ok_pct = 100;
    do_reset(0);
    for (int i = 0; i < 20 && pend_q.size() < 2; i++) step0();
    chk("two_in_flight", pend_q.size(), 2);
    step(1, 32'h1c000100, 0, 32'h0);
    repeat (16) step0();
    chk("br_first_valid", first_del_v, 1);
    chk("br_first_pc", first_del[31:0], 32'h1c000100);

    // redirect vector table
    for (int v = 0; v < 7; v++) begin
      lat_min = vecs[v].lat; lat_max = vecs[v].lat;
      ok_pct = 0; allow_pct = 100;
      repeat (10) step0();
      ok_pct = 100;
      step(vecs[v].br, vecs[v].bt, vecs[v].fl, vecs[v].ft);
      repeat (14) step0();
      chk($sformatf("vec%0d_t1_req", v), t1_req, !vecs[v].exp_ex);
      chk($sformatf("vec%0d_t1_addr", v), t1_addr, vecs[v].exp_pc);
      chk($sformatf("vec%0d_first_valid", v), first_del_v, 1);
      chk($sformatf("vec%0d_first", v), {first_del[64], first_del[31:0]},
          {vecs[v].exp_ex, vecs[v].exp_pc});
      if (vecs[v].exp_ex) chk($sformatf("vec%0d_adef_no_req", v), req_seen, 0);
    end

    // random traffic with redirects and occasional resets
    do_reset(0);
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] t1, t2;
      bit b, f;
      if (c % 50 == 0) begin
        ok_pct    = $urandom_range(100, 30);
        allow_pct = $urandom_range(100, 20);
        lat_min   = 1;
        lat_max   = $urandom_range(6, 1);
      end
      if ($urandom_range(999) == 0) do_reset($urandom_range(1));
      else if ($urandom_range(99) < 3) begin
        t1 = 32'h1c000000 + ($urandom_range(4095) << 2);
        t2 = 32'h1c000000 + ($urandom_range(4095) << 2);
        if ($urandom_range(9) == 0) t1[1:0] = 2'($urandom_range(3, 1));
        b = $urandom_range(1);
        f = !b | ($urandom_range(3) == 0);
        step(b, f ? t2 : t1, f, t1);
      end else step0();
    end
    ok_pct = 0; allow_pct = 100; lat_max = 6;
    repeat (30) step0();
    chk("final_exp_q_empty", exp_q.size(), 0);
    chk("final_pend_empty", pend_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
